regfile_mp: RTL and testbench

Parametrised multi-port integer register file with a per-register busy scoreboard, the successor to the single-write, two-read RV32I register file. It provides NREAD combinational read ports and NWRITE synchronous write ports. Register 0 is hard-wired to zero, and a post-reset clear sweep zeroes the array without per-bit reset flops. It sits between decode and write-back, and is sized for the planned dual-issue, pipelined core.

---
 rtl/regfile_pkg.sv | 23 ++
 rtl/regfile_scoreboard.sv | 76 +++++++
 rtl/regfile_mp.sv | 113 +++++++++++
 tb/tb_regfile_mp.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared definitions for the multi-port register file.
//
// Contents:
//   XLEN_DEF / NREGS_DEF  default data width and register count
//   rf_state_t            clear-sweep FSM state (RF_INIT, RF_RUN)
//   rf_aw(n)              index width for an n-entry register file
//
// Configuration macro used by the register file: REGFILE_MP_BYPASS_EN
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  typedef enum logic {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_t;

  function automatic int rf_aw(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits for the multi-port register file.
//
// Ports:
//   clk          clock, updates on the rising edge
//   rst_n        asynchronous active-low reset, clears every busy bit
//   run_i        high when the register file is in RUN; alloc/we ignored otherwise
//   alloc_i      mark alloc_idx_i busy
//   alloc_idx_i  register to mark busy
//   we_i         write enable per write port (a write clears the target's busy bit)
//   wr_idx_i     write index per write port
//   rs_idx_i     read index per read port
//   rs_busy_o    busy bit per read port (0 while not running)
//
// Configuration: REGFILE_MP_BYPASS_EN makes rs_busy_o reflect a same-cycle
// clear that is not overridden by a same-cycle alloc.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS  = NREGS_DEF,
  parameter int NREAD  = 2,
  parameter int NWRITE = 1,
  parameter int AW     = rf_aw(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run_i,
  input  logic              alloc_i,
  input  logic [AW-1:0]     alloc_idx_i,
  input  logic [NWRITE-1:0] we_i,
  input  logic [NWRITE*AW-1:0] wr_idx_i,
  input  logic [NREAD*AW-1:0]  rs_idx_i,
  output logic [NREAD-1:0]  rs_busy_o
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [NREGS-1:0] clr_mask;
  logic [NREGS-1:0] set_mask;
  logic [NREGS-1:0] busy_view;

  // Set beats clear so a register re-allocated on the same edge it is
  // written stays busy for its newer producer. Bit 0 never becomes busy.
  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    if (run_i) begin
      for (int w = 0; w < NWRITE; w++) begin
        if (we_i[w]) clr_mask[wr_idx_i[w*AW +: AW]] = 1'b1;
      end
      if (alloc_i) set_mask[alloc_idx_i] = 1'b1;
    end
    clr_mask[0] = 1'b0;
    set_mask[0] = 1'b0;
    busy_d = (busy_q & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

`ifdef REGFILE_MP_BYPASS_EN
  // Forward a same-cycle clear unless alloc re-sets the same register.
  assign busy_view = busy_q & ~(clr_mask & ~set_mask);
`else
  assign busy_view = busy_q;
`endif

  always_comb begin
    rs_busy_o = '0;
    for (int p = 0; p < NREAD; p++) begin
      rs_busy_o[p] = run_i & busy_view[rs_idx_i[p*AW +: AW]];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port integer register file with busy scoreboard.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst_n      asynchronous active-low reset; restarts the clear sweep
//   ready      high once the post-reset clear sweep has finished
//   rs_idx     read index per read port, port p at [p*AW +: AW]
//   rs_data    combinational read data per read port (x0 reads 0)
//   rs_busy    scoreboard busy bit per read port
//   we         write enable per write port
//   wr_idx     write index per write port
//   wr_data    write data per write port
//   alloc      mark alloc_idx busy (from decode)
//   alloc_idx  register to mark busy
//
// Configuration: define REGFILE_MP_BYPASS_EN to forward same-cycle write data
// and busy clears to the read ports; undefined, reads see registered state only.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int NREAD  = 2,
  parameter int NWRITE = 1,
  localparam int AW    = rf_aw(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   ready,
  input  logic [NREAD*AW-1:0]    rs_idx,
  output logic [NREAD*XLEN-1:0]  rs_data,
  output logic [NREAD-1:0]       rs_busy,
  input  logic [NWRITE-1:0]      we,
  input  logic [NWRITE*AW-1:0]   wr_idx,
  input  logic [NWRITE*XLEN-1:0] wr_data,
  input  logic                   alloc,
  input  logic [AW-1:0]          alloc_idx
);

  rf_state_t        state_q;
  logic [AW-1:0]    clr_cnt_q;
  logic             ready_q;
  logic             run;
  logic [XLEN-1:0]  regs_q [NREGS];

  assign run   = (state_q == RF_RUN);
  assign ready = ready_q;

  // Clear sweep: one register per edge, RUN after the last index is zeroed.
  // ready is registered alongside the state so it rises on that same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RF_INIT;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
    end else if (state_q == RF_INIT) begin
      clr_cnt_q <= clr_cnt_q + AW'(1);
      if (clr_cnt_q == AW'(NREGS - 1)) begin
        state_q <= RF_RUN;
        ready_q <= 1'b1;
      end
    end
  end

  // The array has no reset; the sweep zeroes it instead. Later write ports
  // are assigned last, so the highest port wins on an index collision.
  always_ff @(posedge clk) begin
    if (state_q == RF_INIT) begin
      regs_q[clr_cnt_q] <= '0;
    end else begin
      for (int w = 0; w < NWRITE; w++) begin
        if (we[w] && (wr_idx[w*AW +: AW] != '0)) begin
          regs_q[wr_idx[w*AW +: AW]] <= wr_data[w*XLEN +: XLEN];
        end
      end
    end
  end

  // Reads are forced to 0 for x0 and throughout the sweep.
  always_comb begin
    rs_data = '0;
    for (int p = 0; p < NREAD; p++) begin
      if (run && (rs_idx[p*AW +: AW] != '0)) begin
        rs_data[p*XLEN +: XLEN] = regs_q[rs_idx[p*AW +: AW]];
`ifdef REGFILE_MP_BYPASS_EN
        for (int w = 0; w < NWRITE; w++) begin
          if (we[w] && (wr_idx[w*AW +: AW] == rs_idx[p*AW +: AW])) begin
            rs_data[p*XLEN +: XLEN] = wr_data[w*XLEN +: XLEN];
          end
        end
`endif
      end
    end
  end

  regfile_scoreboard #(
    .NREGS  (NREGS),
    .NREAD  (NREAD),
    .NWRITE (NWRITE),
    .AW     (AW)
  ) u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .run_i       (run),
    .alloc_i     (alloc),
    .alloc_idx_i (alloc_idx),
    .we_i        (we),
    .wr_idx_i    (wr_idx),
    .rs_idx_i    (rs_idx),
    .rs_busy_o   (rs_busy)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard-style bench for regfile_mp (two read and two write
// ports, 32 x 32-bit). Stimulus pushes hand-computed expectations into a queue;
// a monitor on the falling edge pops them and compares against the DUT.
module tb_regfile_mp;

  localparam int AW = 5;

`ifdef REGFILE_MP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  busy;
    logic        rdy;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          ready;
  logic [2*AW-1:0] rs_idx;
  logic [63:0]   rs_data;
  logic [1:0]    rs_busy;
  logic [1:0]    we;
  logic [2*AW-1:0] wr_idx;
  logic [63:0]   wr_data;
  logic          alloc;
  logic [AW-1:0] alloc_idx;

  exp_t expQ[$];
  exp_t cur;
  int   total = 0;
  int   bad   = 0;

  regfile_mp #(
    .XLEN   (32),
    .NREGS  (32),
    .NREAD  (2),
    .NWRITE (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ready     (ready),
    .rs_idx    (rs_idx),
    .rs_data   (rs_data),
    .rs_busy   (rs_busy),
    .we        (we),
    .wr_idx    (wr_idx),
    .wr_data   (wr_data),
    .alloc     (alloc),
    .alloc_idx (alloc_idx)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: compare every expectation queued during the current cycle.
  always @(negedge clk) begin
    while (expQ.size() != 0) begin
      cur = expQ.pop_front();
      total++;
      if ({rs_data, rs_busy, ready} !== {cur.d1, cur.d0, cur.busy, cur.rdy}) begin
        bad++;
        $display("[TB] FAIL %s: got d0=%h d1=%h busy=%b ready=%b, want d0=%h d1=%h busy=%b ready=%b",
                 cur.name, rs_data[31:0], rs_data[63:32], rs_busy, ready,
                 cur.d0, cur.d1, cur.busy, cur.rdy);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic releaseReset();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic applyStimulus(input logic [1:0] weV,
                               input logic [AW-1:0] w0Idx, input logic [31:0] w0Data,
                               input logic [AW-1:0] w1Idx, input logic [31:0] w1Data,
                               input logic alV, input logic [AW-1:0] alIdx,
                               input logic [AW-1:0] r0, input logic [AW-1:0] r1);
    we        = weV;
    wr_idx    = {w1Idx, w0Idx};
    wr_data   = {w1Data, w0Data};
    alloc     = alV;
    alloc_idx = alIdx;
    rs_idx    = {r1, r0};
  endtask

  task automatic readOnly(input logic [AW-1:0] r0, input logic [AW-1:0] r1);
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, r0, r1);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] d0, input logic [31:0] d1,
                             input logic [1:0] busy, input logic rdy);
    exp_t e;
    e.name = name;
    e.d0   = d0;
    e.d1   = d1;
    e.busy = busy;
    e.rdy  = rdy;
    expQ.push_back(e);
  endtask

  initial begin
    rst_n = 1'b0;
    readOnly(5'd5, 5'd3);
    #1;
    checkOutput("reset", 32'h0, 32'h0, 2'b00, 1'b0);

    // Writes and allocs during the sweep must be ignored.
    applyStimulus(2'b01, 5'd4, 32'hBAD0BAD0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd4, 5'd1);
    releaseReset();
    for (int k = 1; k <= 32; k++) begin
      stepClock();
      if (k == 32) readOnly(5'd4, 5'd4);
      else         rs_idx[2*AW-1:AW] = 5'(k);
      checkOutput($sformatf("sweep%0d", k), 32'h0, 32'h0, 2'b00, k == 32);
    end

    stepClock();
    applyStimulus(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd5);
    checkOutput("wr_x5_same", BYP ? 32'hDEADBEEF : 32'h0, BYP ? 32'hDEADBEEF : 32'h0, 2'b00, 1'b1);
    stepClock();
    readOnly(5'd5, 5'd5);
    checkOutput("rd_x5", 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 1'b1);

    stepClock();
    applyStimulus(2'b01, 5'd0, 32'h1234, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd5);
    checkOutput("wr_x0_same", 32'h0, 32'hDEADBEEF, 2'b00, 1'b1);
    stepClock();
    readOnly(5'd0, 5'd0);
    checkOutput("rd_x0", 32'h0, 32'h0, 2'b00, 1'b1);

    stepClock();
    applyStimulus(2'b11, 5'd7, 32'h11, 5'd7, 32'h22, 1'b0, 5'd0, 5'd7, 5'd7);
    checkOutput("dual_same", BYP ? 32'h22 : 32'h0, BYP ? 32'h22 : 32'h0, 2'b00, 1'b1);
    stepClock();
    readOnly(5'd7, 5'd5);
    checkOutput("dual_x7", 32'h22, 32'hDEADBEEF, 2'b00, 1'b1);

    stepClock();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd9);
    checkOutput("alloc_same", 32'h0, 32'h0, 2'b00, 1'b1);
    stepClock();
    readOnly(5'd9, 5'd9);
    checkOutput("alloc_x9", 32'h0, 32'h0, 2'b11, 1'b1);

    stepClock();
    applyStimulus(2'b01, 5'd9, 32'h99, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd9);
    checkOutput("wr_alloc_same", BYP ? 32'h99 : 32'h0, BYP ? 32'h99 : 32'h0, 2'b11, 1'b1);
    stepClock();
    readOnly(5'd9, 5'd9);
    checkOutput("wr_alloc_x9", 32'h99, 32'h99, 2'b11, 1'b1);

    stepClock();
    applyStimulus(2'b10, 5'd0, 32'h0, 5'd9, 32'hAA, 1'b0, 5'd0, 5'd9, 5'd9);
    checkOutput("wr_x9_same", BYP ? 32'hAA : 32'h99, BYP ? 32'hAA : 32'h99,
                BYP ? 2'b00 : 2'b11, 1'b1);
    stepClock();
    readOnly(5'd9, 5'd9);
    checkOutput("wr_x9", 32'hAA, 32'hAA, 2'b00, 1'b1);

    // alloc of x0 has no effect; x3 exercises same-cycle forwarding.
    stepClock();
    applyStimulus(2'b01, 5'd3, 32'hCAFE, 5'd0, 32'h0, 1'b1, 5'd0, 5'd3, 5'd0);
    checkOutput("bypass_x3", BYP ? 32'hCAFE : 32'h0, 32'h0, 2'b00, 1'b1);
    stepClock();
    readOnly(5'd3, 5'd0);
    checkOutput("rd_x3", 32'hCAFE, 32'h0, 2'b00, 1'b1);

    stepClock();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd5, 5'd3);
    checkOutput("alloc_x5_same", 32'hDEADBEEF, 32'hCAFE, 2'b00, 1'b1);
    stepClock();
    readOnly(5'd5, 5'd3);
    checkOutput("alloc_x5", 32'hDEADBEEF, 32'hCAFE, 2'b01, 1'b1);

    // Reset in RUN with x5 busy.
    stepClock();
    rst_n = 1'b0;
    checkOutput("rst_run", 32'h0, 32'h0, 2'b00, 1'b0);
    releaseReset();
    for (int k = 1; k <= 10; k++) begin
      stepClock();
      checkOutput($sformatf("sweepA%0d", k), 32'h0, 32'h0, 2'b00, 1'b0);
    end

    // Reset again with clr_cnt at 10.
    rst_n = 1'b0;
    checkOutput("rst_init", 32'h0, 32'h0, 2'b00, 1'b0);
    releaseReset();
    for (int k = 1; k <= 32; k++) begin
      stepClock();
      checkOutput($sformatf("sweepB%0d", k), 32'h0, 32'h0, 2'b00, k == 32);
    end

    // Drain the queue with a bounded wait.
    for (int i = 0; i < 4 && expQ.size() != 0; i++) @(negedge clk);
    #1;
    if (expQ.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain: pending=%0d, want 0", expQ.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
